// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the RV32I pipeline datapath and its central sequencer.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             load_use;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ack;
  logic             halt_req;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_flush;
  logic             halted;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Sequencer side: consumes hazard/memory/debug requests, drives enables and status.
  modport master (
    input  load_use, branch_taken, dmem_req, dmem_ack, halt_req,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, halted, err, state,
           stall_cnt, flush_cnt
  );

  // Datapath side: raises requests, obeys enables and flushes.
  modport slave (
    output load_use, branch_taken, dmem_req, dmem_ack, halt_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, halted, err, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage RV32I pipeline: stage enables/flushes,
// memory-wait timeout, debug-halt drain and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.master bus
);

  localparam int unsigned WAIT_W  = $clog2(DMEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_MWAIT  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               halted_q, err_q;
  logic [CNT_W-1:0]   stall_q, flush_q;

  logic live, freeze, advance, drain_go, stall_inc, flush_inc;
  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
  logic ex_mem_en_c, mem_wb_en_c, mem_wb_flush_c;

  // State, wait/drain counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      wait_q   <= '0;
      drain_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
      err_q    <= (state_d == ST_ERROR);
    end
  end

  // Per-cycle action priority (freeze > branch > load-use > none) and next state.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    drain_d        = drain_q;
    pc_en_c        = 1'b0;
    if_id_en_c     = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_en_c     = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_en_c    = 1'b0;
    mem_wb_en_c    = 1'b0;
    mem_wb_flush_c = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    advance        = 1'b0;

    live   = (state_q == ST_RUN) || (state_q == ST_MWAIT) || (state_q == ST_DRAIN);
    freeze = live && bus.dmem_req && !bus.dmem_ack;

    if (live) begin
      if (freeze) begin
        mem_wb_flush_c = 1'b1;
      end else if (bus.branch_taken) begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        mem_wb_en_c   = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        flush_inc     = 1'b1;
        advance       = 1'b1;
      end else if (bus.load_use) begin
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        mem_wb_en_c   = 1'b1;
        id_ex_flush_c = 1'b1;
        stall_inc     = 1'b1;
      end else begin
        pc_en_c     = 1'b1;
        if_id_en_c  = 1'b1;
        id_ex_en_c  = 1'b1;
        ex_mem_en_c = 1'b1;
        mem_wb_en_c = 1'b1;
        advance     = 1'b1;
      end
    end

    // A drain cycle is any advancing cycle in DRAIN, or the clean RUN cycle that starts the halt.
    drain_go = advance && ((state_q == ST_DRAIN) ||
                           ((state_q == ST_RUN) && bus.halt_req && !bus.branch_taken));
    // Fetch stops while draining; a redirect still loads PC so the target survives the halt.
    if (drain_go && !bus.branch_taken) begin
      pc_en_c       = 1'b0;
      if_id_flush_c = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_MWAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MWAIT, ST_DRAIN: begin
        if (freeze) begin
          if (wait_q == WAIT_W'(DMEM_TIMEOUT - 1)) state_d = ST_ERROR;
          else                                     wait_d  = wait_q + WAIT_W'(1);
        end else begin
          wait_d = '0;
          if (state_q == ST_MWAIT) state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!bus.halt_req) state_d = ST_RUN;
      end
      ST_ERROR: begin
        mem_wb_flush_c = 1'b1;
      end
      default: state_d = ST_ERROR;
    endcase

    if (drain_go) begin
      if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
        state_d = ST_HALTED;
        drain_d = '0;
      end else begin
        state_d = ST_DRAIN;
        drain_d = drain_q + DRAIN_W'(1);
      end
    end
  end

  // Saturating performance counters of inserted bubbles and redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Reset forces every stage closed and loading NOPs.
  assign bus.pc_en        = rst_n && pc_en_c;
  assign bus.if_id_en     = rst_n && if_id_en_c;
  assign bus.id_ex_en     = rst_n && id_ex_en_c;
  assign bus.ex_mem_en    = rst_n && ex_mem_en_c;
  assign bus.mem_wb_en    = rst_n && mem_wb_en_c;
  assign bus.if_id_flush  = !rst_n || if_id_flush_c;
  assign bus.id_ex_flush  = !rst_n || id_ex_flush_c;
  assign bus.mem_wb_flush = !rst_n || mem_wb_flush_c;
  assign bus.halted       = halted_q;
  assign bus.err          = err_q;
  assign bus.state        = state_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule
